// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the execute-stage operand muxes and the ALU execution unit.
// The master drives operands and the op code, and the slave returns the result.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alucontrol, srca, srcb, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alucontrol, srca, srcb, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked, registered ALU execution unit driven by the 3-bit alucontrol code.
// Define ALU_SHIFT_EN to build in the multi-cycle serial shifter (sll/srl); otherwise those codes are illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             illegal_r;
    logic [WIDTH-1:0] alu_res_s;
    logic             legal_s;

`ifdef ALU_SHIFT_EN
    logic [WIDTH-1:0] shreg_r;
    logic [SHW-1:0]   cnt_r;
    logic             shl_r;
    logic             is_shift_s;
`endif

    // Single-cycle datapath; unsupported codes produce zero so the flag logic needs no special case.
    function automatic logic [WIDTH-1:0] alu_calc(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: ok = 1'b1;
            3'b110, 3'b111:                         ok = SHIFT_EN;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Decode the presented op code and compute the single-cycle result.
    always_comb begin
        alu_res_s = alu_calc(bus.alucontrol, bus.srca, bus.srcb);
        legal_s   = op_legal(bus.alucontrol);
`ifdef ALU_SHIFT_EN
        is_shift_s = 1'b0;
        if (bus.alucontrol[2:1] == 2'b11) begin
            is_shift_s = 1'b1;
        end else begin
            is_shift_s = 1'b0;
        end
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            illegal_r   <= 1'b0;
`ifdef ALU_SHIFT_EN
            shreg_r     <= {WIDTH{1'b0}};
            cnt_r       <= {SHW{1'b0}};
            shl_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
`ifdef ALU_SHIFT_EN
                        if (is_shift_s) begin
                            shreg_r <= bus.srca;
                            cnt_r   <= bus.srcb[SHW-1:0];
                            shl_r   <= ~bus.alucontrol[0];
                            state_r <= BUSY;
                        end else begin
                            result_r    <= alu_res_s;
                            zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                            illegal_r   <= ~legal_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end
`else
                        result_r    <= alu_res_s;
                        zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                        illegal_r   <= ~legal_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
`ifdef ALU_SHIFT_EN
                // One bit per cycle; a zero count still spends one cycle here.
                BUSY: begin
                    if (cnt_r != {SHW{1'b0}}) begin
                        if (shl_r) begin
                            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
                        end
                        cnt_r <= cnt_r - SHW'(1);
                    end else begin
                        result_r    <= shreg_r;
                        zero_r      <= (shreg_r == {WIDTH{1'b0}});
                        illegal_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, backpressure, illegal codes,
// optional shifter (when ALU_SHIFT_EN is defined) and randomized ops against a behavioural model.
module tb_alu_exec_unit;
    localparam int W = 32;

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural reference: what the op should produce, straight from the op table.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd6:    return SHIFT_EN ? (a << (b % 32)) : 32'd0;
            3'd7:    return SHIFT_EN ? (a >> (b % 32)) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [2:0] op);
        return (op == 3'd4) || (!SHIFT_EN && op >= 3'd6);
    endfunction

    // Cycles between the accepting edge and the edge after which out_valid is seen.
    function automatic int ref_wait(input logic [2:0] op, input logic [31:0] b);
        if (SHIFT_EN && op >= 3'd6) return int'(b % 32) + 1;
        return 0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic rdy);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.alucontrol = op;
        bus.srca       = a;
        bus.srcb       = b;
        rdy            = bus.in_ready;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Issue one op with out_ready held high and report what the DUT returned.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic rdy, output int waited, output logic [31:0] res,
                          output logic z, output logic ill, output logic post_valid, output logic post_ready);
        bus.out_ready = 1'b1;
        issue(op, a, b, rdy);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        res = bus.result;
        z   = bus.zero;
        ill = bus.illegal;
        @(posedge clk);
        #1;
        post_valid = bus.out_valid;
        post_ready = bus.in_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        if (bus.result !== 32'd0)   begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        if (bus.zero !== 1'b1)      begin errors++; $display("FAIL reset_zero got %b want 1", bus.zero); end
        if (bus.illegal !== 1'b0)   begin errors++; $display("FAIL reset_illegal got %b want 0", bus.illegal); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd1, 3'd0, 3'd5, 3'd5, 3'd2, 3'd3};
        logic [31:0] as  [6] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h0000_F0F0, 32'h0000_F0F0};
        logic [31:0] bs  [6] = '{32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'h0000_0FF0, 32'h0000_0FF0};
        logic [31:0] exp [6] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'h0000_00F0, 32'h0000_FFF0};
        logic rdy, z, ill, pv, pr;
        int waited;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], rdy, waited, res, z, ill, pv, pr);
            checks += 6;
            if (rdy !== 1'b1)   begin errors++; $display("FAIL dir%0d_accept in_ready %b want 1", i, rdy); end
            if (waited !== 0)   begin errors++; $display("FAIL dir%0d_latency got %0d want 0", i, waited); end
            if (res !== exp[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, exp[i]); end
            if (z !== (exp[i] == 32'd0)) begin errors++; $display("FAIL dir%0d_zero got %b want %b", i, z, exp[i] == 32'd0); end
            if (ill !== 1'b0)   begin errors++; $display("FAIL dir%0d_illegal got %b want 0", i, ill); end
            if (pv !== 1'b0 || pr !== 1'b1) begin errors++; $display("FAIL dir%0d_consume out_valid %b in_ready %b want 0 1", i, pv, pr); end
        end
    endtask

    task automatic test_backpressure();
        logic rdy, z, ill, pv, pr;
        int waited;
        logic [31:0] res;
        bus.out_ready = 1'b0;
        issue(3'd0, 32'd3, 32'd4, rdy);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 100) begin @(posedge clk); #1; waited++; end
        // A competing request while the result is parked must be ignored.
        bus.in_valid = 1'b1; bus.alucontrol = 3'd1; bus.srca = 32'd100; bus.srcb = 32'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks += 3;
            if (bus.result !== 32'd7)   begin errors++; $display("FAIL bp_hold%0d_result got %h want 7", c, bus.result); end
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_out_valid got %b want 1", c, bus.out_valid); end
            if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL bp_hold%0d_in_ready got %b want 0", c, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks += 2;
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
        run_op(3'd3, 32'h1, 32'h2, rdy, waited, res, z, ill, pv, pr);
        checks++;
        if (res !== 32'h3) begin errors++; $display("FAIL bp_next_result got %h want 3", res); end
    endtask

    task automatic test_illegal();
        logic [2:0] op;
        logic rdy, z, ill, pv, pr;
        int waited;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            op = (i == 0) ? 3'd4 : ((i == 1) ? 3'd6 : 3'd7);
            if (ref_illegal(op)) begin
                run_op(op, $urandom, $urandom, rdy, waited, res, z, ill, pv, pr);
                checks += 4;
                if (waited !== 0)   begin errors++; $display("FAIL ill%0d_latency got %0d want 0", op, waited); end
                if (ill !== 1'b1)   begin errors++; $display("FAIL ill%0d_flag got %b want 1", op, ill); end
                if (res !== 32'd0)  begin errors++; $display("FAIL ill%0d_result got %h want 0", op, res); end
                if (z !== 1'b1)     begin errors++; $display("FAIL ill%0d_zero got %b want 1", op, z); end
            end
        end
    endtask

    task automatic test_shift();
        logic rdy, z, ill, pv, pr;
        int waited;
        int seen;
        logic [31:0] res;
        if (SHIFT_EN) begin
            run_op(3'd6, 32'd1, 32'd31, rdy, waited, res, z, ill, pv, pr);
            checks += 2;
            if (waited !== 32)          begin errors++; $display("FAIL sll31_latency got %0d want 32", waited); end
            if (res !== 32'h8000_0000)  begin errors++; $display("FAIL sll31_result got %h want 80000000", res); end
            run_op(3'd7, 32'hA5A5_1234, 32'd0, rdy, waited, res, z, ill, pv, pr);
            checks += 2;
            if (waited !== 1)           begin errors++; $display("FAIL srl0_latency got %0d want 1", waited); end
            if (res !== 32'hA5A5_1234)  begin errors++; $display("FAIL srl0_result got %h want a5a51234", res); end
            // Abort a long shift with reset and make sure nothing leaks out afterwards.
            bus.out_ready = 1'b1;
            issue(3'd6, 32'hFFFF_FFFF, 32'd20, rdy);
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            checks += 3;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", bus.out_valid); end
            if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready); end
            if (bus.result !== 32'd0)   begin errors++; $display("FAIL abort_result got %h want 0", bus.result); end
            seen = 0;
            repeat (25) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen++; end
            checks++;
            if (seen !== 0) begin errors++; $display("FAIL abort_spurious got %0d want 0", seen); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, er;
        logic rdy, z, ill, pv, pr;
        int waited;
        logic [31:0] res;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            er = ref_result(op, a, b);
            run_op(op, a, b, rdy, waited, res, z, ill, pv, pr);
            checks += 5;
            if (rdy !== 1'b1)               begin errors++; $display("FAIL rnd%0d_accept in_ready %b want 1", i, rdy); end
            if (waited !== ref_wait(op, b)) begin errors++; $display("FAIL rnd%0d_latency op %0d got %0d want %0d", i, op, waited, ref_wait(op, b)); end
            if (res !== er)                 begin errors++; $display("FAIL rnd%0d_result op %0d got %h want %h", i, op, res, er); end
            if (z !== (er == 32'd0))        begin errors++; $display("FAIL rnd%0d_zero got %b want %b", i, z, er == 32'd0); end
            if (ill !== ref_illegal(op))    begin errors++; $display("FAIL rnd%0d_illegal got %b want %b", i, ill, ref_illegal(op)); end
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.alucontrol = 3'd0;
        bus.srca       = 32'd0;
        bus.srcb       = 32'd0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
